// File: rtl/bubbledrive_power_supervisor.sv
// rtl/bubbledrive_power_supervisor.sv - BubbleDrive8 power/mode supervisor
// Filters PWRSTAT/MRST, picks emulator/MPSSE/error mode, drives enables and LEDs.
module bubbledrive_power_supervisor #(
  parameter int DEBOUNCE_CYCLES   = 4800,
  parameter int SETTLE_CYCLES     = 480000,
  parameter int BLINK_HALF_CYCLES = 48000000,
  parameter int SETTINGS_W        = 10
) (
  input  logic                  MCLK,
  input  logic                  nRESET,
  input  logic                  PWRSTAT,
  input  logic                  MRST,
  input  logic [SETTINGS_W-1:0] DIP_IN,
  output logic [SETTINGS_W-1:0] SETTINGS,
  output logic [2:0]            STATE,
  output logic                  nEMUCORE_EN,
  output logic                  nTEMPSENSE_EN,
  output logic                  nFIFO_EN,
  output logic                  nMPSSE_EN,
  output logic                  nLED_PWROK,
  output logic                  nLED_STANDBY,
  output logic                  nLED_DELAYING
);

  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 3);
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam int BLINK_W = $clog2(BLINK_HALF_CYCLES + 1);

  localparam logic [DEB_W-1:0]   DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEB_W-1:0]   START_LAST  = DEB_W'(DEBOUNCE_CYCLES + 1);
  localparam logic [SET_W-1:0]   SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST  = BLINK_W'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_RESET      = 3'd0,
    ST_EVAL       = 3'd1,
    ST_EMU_SETTLE = 3'd2,
    ST_EMU_RUN    = 3'd3,
    ST_MPSSE      = 3'd5,
    ST_ERR_BOARD  = 3'd6,
    ST_ERR_AMBIG  = 3'd7
  } state_t;

  state_t             state;
  logic [1:0]         raw_in;
  logic [1:0]         sync_1;
  logic [1:0]         sync_2;
  logic [1:0]         filt;
  logic [DEB_W-1:0]   deb_cnt [2];
  logic [DEB_W-1:0]   start_cnt;
  logic               valid;
  logic [SET_W-1:0]   settle_cnt;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink;
  logic               blink_run;

  // bit 1 carries PWRSTAT, bit 0 carries MRST, so filt reads directly as PM
  assign raw_in    = {PWRSTAT, MRST};
  assign STATE     = state;
  assign blink_run = (state == ST_MPSSE) || (state == ST_ERR_BOARD) || (state == ST_ERR_AMBIG);

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      sync_1     <= '0;
      sync_2     <= '0;
      filt       <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync_1 <= raw_in;
      sync_2 <= sync_1;
      for (int i = 0; i < 2; i++) begin
        if (sync_2[i] == filt[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          filt[i]    <= sync_2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  // Hold the FSM in RESET until the synchronisers and filters have had time to settle
  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      start_cnt <= '0;
      valid     <= 1'b0;
    end else if (!valid) begin
      if (start_cnt == START_LAST) begin
        valid <= 1'b1;
      end
      start_cnt <= start_cnt + DEB_W'(1);
    end
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state         <= ST_RESET;
      settle_cnt    <= '0;
      SETTINGS      <= '0;
      nEMUCORE_EN   <= 1'b1;
      nTEMPSENSE_EN <= 1'b1;
      nFIFO_EN      <= 1'b1;
      nMPSSE_EN     <= 1'b1;
      nLED_PWROK    <= 1'b1;
      nLED_STANDBY  <= 1'b1;
      nLED_DELAYING <= 1'b1;
    end else begin
      case (state)
        ST_RESET: begin
          SETTINGS <= ~DIP_IN;
          if (valid) begin
            state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          case (filt)
            2'b00:   state <= ST_EMU_SETTLE;
            2'b01:   state <= ST_ERR_BOARD;
            2'b10:   state <= ST_ERR_AMBIG;
            default: state <= ST_MPSSE;
          endcase
        end
        ST_EMU_SETTLE: begin
          if (filt != 2'b00) begin
            state <= ST_RESET;
          end else if (settle_cnt == SETTLE_LAST) begin
            state <= ST_EMU_RUN;
          end
        end
        ST_EMU_RUN: begin
          if (filt != 2'b00) begin
            state <= ST_RESET;
          end
        end
        ST_MPSSE: begin
          if (filt != 2'b11) begin
            state <= ST_RESET;
          end
        end
        ST_ERR_BOARD: begin
          if (!filt[0]) begin
            state <= ST_RESET;
          end
        end
        ST_ERR_AMBIG: begin
          if (filt != 2'b10) begin
            state <= ST_RESET;
          end
        end
        default: state <= ST_RESET;
      endcase

      if ((state == ST_EMU_SETTLE) && (filt == 2'b00) && (settle_cnt != SETTLE_LAST)) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end else begin
        settle_cnt <= '0;
      end

      nEMUCORE_EN   <= (state != ST_EMU_RUN);
      nTEMPSENSE_EN <= (state != ST_EMU_RUN);
      nFIFO_EN      <= (state != ST_EMU_RUN);
      nMPSSE_EN     <= (state != ST_MPSSE);
      nLED_DELAYING <= !((state == ST_EMU_SETTLE) || (state == ST_EMU_RUN));
      nLED_STANDBY  <= (state == ST_MPSSE) ? blink : 1'b1;
      case (state)
        ST_EMU_RUN, ST_MPSSE:        nLED_PWROK <= 1'b0;
        ST_ERR_BOARD, ST_ERR_AMBIG:  nLED_PWROK <= blink;
        default:                     nLED_PWROK <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (!blink_run) begin
      blink     <= 1'b1;
      blink_cnt <= '0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink     <= ~blink;
      blink_cnt <= '0;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

endmodule

// File: doc/bubbledrive_power_supervisor.md
Name: bubbledrive_power_supervisor

Overview:
Parametrised power/mode supervisor for the BubbleDrive8 top level.
- Filters PWRSTAT/MRST, then selects emulator, MPSSE-standby or error mode.
- Drives the active-low enables for emucore, tempsense, the FIFO path and MPSSE, plus the status LEDs.
- Adds what the current controller lacks: input debounce, a settle delay before the emulator is enabled, exit from emulator mode on power loss, a parametrised blink rate and a parametrised settings latch.

Parameters:
- DEBOUNCE_CYCLES, 4800: consecutive cycles a synchronised input must differ from its filtered value before the filtered value updates.
- SETTLE_CYCLES, 480000: cycles power must stay in emulator condition before the enables assert.
- BLINK_HALF_CYCLES, 48000000: blink half-period in MCLK cycles.
- SETTINGS_W, 10: width of the latched DIP settings bus.

Ports:
- MCLK, in, 1: 48 MHz clock.
- nRESET, in, 1: asynchronous active-low reset.
- PWRSTAT, in, 1: power MUX status, asynchronous (0 = motherboard, 1 = USB).
- MRST, in, 1: PCB power status, asynchronous (0 = good).
- DIP_IN, in, SETTINGS_W: raw active-low switch inputs.
- SETTINGS, out, SETTINGS_W: latched ~DIP_IN.
- STATE, out, 3: current state code.
- nEMUCORE_EN, out, 1: emucore enable, active low.
- nTEMPSENSE_EN, out, 1: tempsense enable, active low.
- nFIFO_EN, out, 1: FIFO path enable, active low.
- nMPSSE_EN, out, 1: MPSSE enable, active low.
- nLED_PWROK, out, 1: power-OK LED, active low.
- nLED_STANDBY, out, 1: standby LED, active low.
- nLED_DELAYING, out, 1: delaying LED, active low.

Behaviour:
Reset values (nRESET low):
- All enables = 1, all LEDs = 1, SETTINGS = 0, STATE = 0, blink = 1.
- Filtered PWRSTAT/MRST = 0; all counters = 0; valid flag = 0.
- nRESET asserted at any time returns everything here immediately, including mid-operation.

Input conditioning:
- PWRSTAT and MRST each pass through a 2-flop synchroniser.
- Per-input debounce counter: increments while sync != filt, clears when they are equal. When the counter reaches DEBOUNCE_CYCLES-1 with sync still != filt, filt takes sync and the counter clears.
- Startup counter counts from reset release and sets the sticky valid flag after DEBOUNCE_CYCLES+2 cycles.

State machine (code in brackets), evaluated on filtered P = PWRSTAT, M = MRST:
- RESET [0]: SETTINGS <= ~DIP_IN every cycle. Go to EVAL once valid = 1.
- EVAL [1]: SETTINGS frozen from here on. PM = 00 -> EMU_SETTLE; 01 -> ERR_BOARD; 10 -> ERR_AMBIG; 11 -> MPSSE.
- EMU_SETTLE [2]: settle counter increments each cycle. PM != 00 -> RESET, settle counter cleared. Counter reaching SETTLE_CYCLES-1 -> EMU_RUN.
- EMU_RUN [3]: stay while PM = 00; otherwise -> RESET.
- MPSSE [5]: stay while PM = 11; otherwise -> RESET.
- ERR_BOARD [6]: stay while M = 1; otherwise -> RESET.
- ERR_AMBIG [7]: stay while PM = 10; otherwise -> RESET.
- Unused code 4 -> RESET next cycle.

Outputs:
- All registered from the current state, so they change 1 cycle after state entry. STATE is the state register itself.
- EMU_RUN: nEMUCORE_EN = 0, nTEMPSENSE_EN = 0, nFIFO_EN = 0, nMPSSE_EN = 1.
- MPSSE: nMPSSE_EN = 0; other enables 1.
- All other states: all enables 1.
- nLED_PWROK: 0 in EMU_RUN and MPSSE; follows blink in ERR_BOARD/ERR_AMBIG; 1 otherwise.
- nLED_STANDBY: follows blink in MPSSE; 1 otherwise.
- nLED_DELAYING: 0 in EMU_SETTLE and EMU_RUN; 1 otherwise.

Blinker:
- Runs only in MPSSE, ERR_BOARD and ERR_AMBIG. In any other state blink = 1 and the blink counter = 0.
- While running, the counter increments. At BLINK_HALF_CYCLES-1 blink toggles and the counter clears.
- First low phase therefore begins BLINK_HALF_CYCLES cycles after entry.
- Moving directly between two running states (impossible via the FSM, since every exit passes through RESET) would not be required to restart the blinker.

Simultaneous events:
- Both inputs changing in the same cycle: each is filtered independently; the FSM acts on whichever filtered values are present that cycle.
- Glitch shorter than DEBOUNCE_CYCLES: no state change.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES = 4, SETTLE_CYCLES = 8, BLINK_HALF_CYCLES = 5.
1. Startup, PM = 00, DIP_IN = 10'h3F0 -> STATE goes 0 -> 1 -> 2 -> 3. Enables go low 9 cycles after STATE = 2. SETTINGS = 10'h00F and stays fixed when DIP_IN later changes.
2. In EMU_RUN, MRST high for 3 cycles -> no change. High for 6 cycles -> STATE = 0; nEMUCORE_EN returns to 1; the FSM re-enters via EVAL into ERR_BOARD.
3. PM = 11 -> STATE = 5, nMPSSE_EN = 0, nLED_PWROK = 0. nLED_STANDBY toggles every 5 cycles, starting high.
4. PM = 10 -> STATE = 7, nLED_PWROK blinks with period 10, all enables 1. Set PM = 00 -> through RESET and EVAL to EMU_SETTLE.
5. PM = 01 during EMU_SETTLE at count 5 -> STATE = 0, no enable ever asserted. After returning to PM = 00, the full 8-cycle settle is required again.
6. nRESET pulsed low in EMU_RUN -> all outputs immediately at reset values; recovery repeats scenario 1 timing.
